// File: rtl/pipe_pkg.sv
// Shared constants and sizing helpers for the valid/ready register chain.
package pipe_pkg;

  localparam int RDY_COMB = 0;
  localparam int RDY_REG  = 1;

  function automatic int stage_cap(input int reg_rdy);
    return (reg_rdy == RDY_REG) ? 2 : 1;
  endfunction

  // Width needed to count 0..CAP held entries.
  function automatic int cnt_w(input int depth, input int reg_rdy);
    return $clog2(depth * stage_cap(reg_rdy) + 1);
  endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// One valid/ready register stage: either a skid buffer (registered ready)
// or a simple pipeline register (combinational ready).
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int REG_RDY = RDY_REG
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] out_data
);

  if (REG_RDY == RDY_REG) begin : g_skid
    logic              main_vld;
    logic              skid_vld;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;
    logic              in_fire;
    logic              main_free;

    assign in_fire   = in_vld & ~skid_vld;
    assign main_free = ~main_vld | out_rdy;

    // A stalled main register diverts the incoming word into the skid slot;
    // the skid word always has priority when main frees up.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        main_vld <= 1'b0;
        skid_vld <= 1'b0;
      end else if (flush) begin
        main_vld <= 1'b0;
        skid_vld <= 1'b0;
      end else if (main_free) begin
        if (skid_vld) begin
          main_vld <= 1'b1;
          skid_vld <= 1'b0;
        end else begin
          main_vld <= in_fire;
        end
      end else if (in_fire) begin
        skid_vld <= 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        main_data <= '0;
        skid_data <= '0;
      end else if (!flush) begin
        if (main_free) begin
          if (skid_vld) begin
            main_data <= skid_data;
          end else if (in_fire) begin
            main_data <= in_data;
          end
        end else if (in_fire) begin
          skid_data <= in_data;
        end
      end
    end

    assign in_rdy   = ~skid_vld;
    assign out_vld  = main_vld;
    assign out_data = main_data;
  end else begin : g_simple
    logic              vld;
    logic [DATA_W-1:0] data;

    assign in_rdy = ~vld | out_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld <= 1'b0;
      end else if (flush) begin
        vld <= 1'b0;
      end else if (in_rdy) begin
        vld <= in_vld;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data <= '0;
      end else if (!flush && in_rdy && in_vld) begin
        data <= in_data;
      end
    end

    assign out_vld  = vld;
    assign out_data = data;
  end

endmodule

// File: rtl/pipe_skid_chain.sv
// DEPTH valid/ready stages in series with flush gating and an entry counter.
module pipe_skid_chain
  import pipe_pkg::*;
#(
  parameter int  DATA_W  = 16,
  parameter int  DEPTH   = 2,
  parameter int  REG_RDY = RDY_REG,
  localparam int CAP     = DEPTH * stage_cap(REG_RDY),
  localparam int CNT_W   = cnt_w(DEPTH, REG_RDY)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  occupancy
);

  // Per-stage nets live inside each generate block so the ready path of a
  // combinational-ready chain is not one self-referencing vector.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic              s_in_vld;
    logic              s_in_rdy;
    logic [DATA_W-1:0] s_in_data;
    logic              s_out_vld;
    logic              s_out_rdy;
    logic [DATA_W-1:0] s_out_data;

    if (k == 0) begin : g_head
      assign s_in_vld  = in_vld & ~flush;
      assign s_in_data = in_data;
    end else begin : g_link
      assign s_in_vld  = g_stage[k-1].s_out_vld;
      assign s_in_data = g_stage[k-1].s_out_data;
    end

    if (k == DEPTH - 1) begin : g_tail
      assign s_out_rdy = out_rdy;
    end else begin : g_next
      assign s_out_rdy = g_stage[k+1].s_in_rdy;
    end

    pipe_skid_stage #(
      .DATA_W  (DATA_W),
      .REG_RDY (REG_RDY)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_vld   (s_in_vld),
      .in_rdy   (s_in_rdy),
      .in_data  (s_in_data),
      .out_vld  (s_out_vld),
      .out_rdy  (s_out_rdy),
      .out_data (s_out_data)
    );
  end

  assign in_rdy   = g_stage[0].s_in_rdy & ~flush;
  assign out_vld  = g_stage[DEPTH-1].s_out_vld & ~flush;
  assign out_data = g_stage[DEPTH-1].s_out_data;

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_vld & in_rdy;
  assign out_fire = out_vld & out_rdy;

  // Port transfers are already flush-gated; flush itself empties the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else begin
      case ({in_fire, out_fire})
        2'b10: if (occupancy != CNT_W'(CAP)) occupancy <= occupancy + CNT_W'(1);
        2'b01: if (occupancy != '0) occupancy <= occupancy - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: doc/pipe_skid_chain.md
PIPE_SKID_CHAIN -- requirements
Module: pipe_skid_chain

Interface
REQ-001 Parameter DATA_W, default 16, payload width in bits (>=1).
REQ-002 Parameter DEPTH, default 2, number of register stages (>=1).
REQ-003 Parameter REG_RDY, default 1; 1 = skid stage (registered ready, 2 entries/stage), 0 = simple stage (combinational ready, 1 entry/stage).
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous discard of all held entries.
REQ-007 in_vld  input  1  upstream data valid.
REQ-008 in_rdy  output  1  chain can accept this cycle.
REQ-009 in_data  input  DATA_W  upstream payload.
REQ-010 out_vld  output  1  downstream data valid.
REQ-011 out_rdy  input  1  downstream can accept.
REQ-012 out_data  output  DATA_W  downstream payload, registered.
REQ-013 occupancy  output  CNT_W  entries held; CNT_W = clog2(CAP+1), CAP = DEPTH*(REG_RDY?2:1).

Function
REQ-014 Transfer on a port occurs when vld and rdy are both high at a rising edge; vld/data held stable until transfer.
REQ-015 Stages are chained in series; stage k output feeds stage k+1 input via the same vld/rdy rule.
REQ-016 Order preserved; no word dropped or duplicated except by flush.
REQ-017 Empty-chain latency: word accepted at edge N is presented with out_vld=1 after edge N+DEPTH-1, i.e. visible DEPTH cycles after acceptance counting the acceptance edge.
REQ-018 With out_rdy=1 continuously, throughput one word per cycle, no bubbles, both modes.
REQ-019 REG_RDY=1 stage: main and skid registers; stage in_rdy = ~skid_vld, driven directly from a flop.
REQ-020 REG_RDY=1: input arriving while main full and downstream stalled goes to skid; on downstream accept, main loads skid if skid_vld, else loads input.
REQ-021 REG_RDY=0 stage: in_rdy = ~vld | downstream rdy; load on accept; vld <= in_vld when in_rdy.
REQ-022 Full chain: in_rdy=0 exactly when occupancy==CAP (REG_RDY=1 asserts once last stage's skid fills backwards).
REQ-023 occupancy +1 on input transfer, -1 on output transfer, unchanged on both same cycle; never exceeds CAP nor underflows.
REQ-024 flush=1: in_rdy and out_vld forced 0 same cycle (combinational gating); next edge clears every valid bit and occupancy to 0; data registers keep contents.
REQ-025 flush has priority over all transfers in that cycle.
REQ-026 Simultaneous full and out transfer: freed slot accepted same cycle in REG_RDY=0; in REG_RDY=1 in_rdy reopens on the following cycle.

Reset
REQ-027 rst_n low asynchronously clears all valid bits, all data registers to 0, occupancy to 0.
REQ-028 During and after reset: out_vld=0, out_data=0, occupancy=0, in_rdy=1 (unless flush=1).
REQ-029 Reset mid-stream discards all held words; first post-reset accepted word follows REQ-017 latency.

Structure
REQ-030 Shared package pipe_pkg holds CNT_W function (clog2-based) and mode constants RDY_COMB=0, RDY_REG=1.
REQ-031 One sub-module pipe_skid_stage (params DATA_W, REG_RDY; ports clk, rst_n, flush, in/out vld/rdy/data), instantiated DEPTH times via generate.
REQ-032 Occupancy counter lives in top level, not in stages.

Verification
REQ-033 Reset: assert rst_n=0 mid-traffic -> out_vld=0, out_data=16'h0000, occupancy=0, in_rdy=1 immediately.
REQ-034 Stream DEPTH=2, REG_RDY=1, out_rdy=1, inputs 16'h0001..16'h0008 back-to-back -> outputs same 8 values consecutive cycles, first 2 cycles after acceptance.
REQ-035 Backpressure out_rdy=0, in_vld=1 -> exactly 4 words accepted, occupancy=4, in_rdy=0; release out_rdy -> 4 words in order, occupancy returns to 0.
REQ-036 out_rdy toggling 1/0 every cycle, 20 random words -> scoreboard exact order, no loss/duplication, occupancy never >4.
REQ-037 Flush with occupancy=3 -> next cycle out_vld=0, occupancy=0; then send 16'hBEEF -> emerges alone after 2 cycles.
REQ-038 REG_RDY=0, DEPTH=2, full, out_rdy=1 with in_vld=1 -> in_rdy=1 same cycle, occupancy stays 2.
